// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller:
// parameter defaults, width helpers and FSM state encodings.
package icache_refill_ctrl_pkg;

  localparam int DEF_ASSOC       = 2;
  localparam int DEF_SETS        = 16;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_ADDR_BITS   = 32;

  // Field widths for a geometry; width_of keeps counters/selectors at least 1 bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_width(input int addr_bits, input int sets, input int block_words);
    return addr_bits - $clog2(sets) - $clog2(block_words) - 2;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_REFILL = 3'd2,
    ST_FILL   = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

endpackage

// File: rtl/icache_refill_ctrl_plru.sv
// Victim selection and pseudo-LRU status update for one set.
module icache_plru #(
  parameter int ASSOC = 2,
  parameter int WAY_W = 1
) (
  input  logic [ASSOC-1:0] valid,
  input  logic [ASSOC-1:0] status,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [ASSOC-1:0] status_next
);

  logic             found;
  logic [ASSOC-1:0] access_onehot;

  // Invalid ways take priority over the lowest not-recently-used way.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    for (int w = 0; w < ASSOC; w++) begin
      if (!found && !status[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  // Once every way is marked used, only the accessed way keeps its mark.
  always_comb begin
    access_onehot = ASSOC'(1) << access_way;
    status_next   = status | access_onehot;
    if (&status_next) status_next = access_onehot;
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Set-associative instruction cache with zero-cycle hits, blocking block refill
// over a request/ack + beat interface, PLRU replacement and whole-cache flush.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ASSOC       = DEF_ASSOC,
  parameter int SETS        = DEF_SETS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_data,
  input  logic                 flush,
  output logic                 busy,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_data,
  output logic [2:0]           fsm_state
);

  // Handshakes: cpu_req/cpu_addr are held by the CPU until the cycle cpu_ready is
  // high; mem_req/mem_addr are held until the cycle mem_ack is high; each mem_valid
  // cycle carries exactly one beat and has no back-pressure.
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = width_of(SETS);
  localparam int CNT_W  = width_of(BLOCK_WORDS);
  localparam int WAY_W  = width_of(ASSOC);
  localparam int TAG_W  = tag_width(ADDR_BITS, SETS, BLOCK_WORDS);
  localparam logic [ADDR_BITS-1:0] BLK_MASK = ~ADDR_BITS'(BLOCK_WORDS * 4 - 1);

  state_t state_q, state_d;

  logic [ASSOC-1:0] valid_q  [SETS];
  logic [ASSOC-1:0] status_q [SETS];
  logic [TAG_W-1:0] tag_arr  [ASSOC][SETS];
  logic [31:0]      data_arr [ASSOC][SETS][BLOCK_WORDS];
  logic [31:0]      buf_q    [BLOCK_WORDS];

  logic [ADDR_BITS-1:0] blk_addr_q;
  logic [IDX_W-1:0]     idx_q, flush_idx_q;
  logic [TAG_W-1:0]     tag_lat_q;
  logic [WAY_W-1:0]     victim_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 flush_pend_q;

  logic [CNT_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx, sel_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit_any, hit, miss;
  logic [WAY_W-1:0] hit_way, plru_victim, plru_access;
  logic [ASSOC-1:0] status_next;

  assign req_off = cpu_addr[2 +: CNT_W] & CNT_W'(BLOCK_WORDS - 1);
  assign req_idx = cpu_addr[OFF_W + 2 +: IDX_W] & IDX_W'(SETS - 1);
  assign req_tag = cpu_addr[ADDR_BITS-1 -: TAG_W];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!hit_any && valid_q[req_idx][w] && (tag_arr[w][req_idx] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // A coincident flush pulse suppresses the hit so the flush is never delayed.
  assign hit  = (state_q == ST_IDLE) && cpu_req && !flush && hit_any;
  assign miss = (state_q == ST_IDLE) && cpu_req && !flush && !hit_any;

  assign cpu_ready = hit;
  assign cpu_data  = hit ? data_arr[hit_way][req_idx][req_off] : 32'd0;
  assign mem_addr  = blk_addr_q;
  assign fsm_state = state_q;

  assign sel_idx     = (state_q == ST_FILL) ? idx_q : req_idx;
  assign plru_access = (state_q == ST_FILL) ? victim_q : hit_way;

  icache_plru #(.ASSOC(ASSOC), .WAY_W(WAY_W)) u_plru (
    .valid       (valid_q[sel_idx]),
    .status      (status_q[sel_idx]),
    .access_way  (plru_access),
    .victim      (plru_victim),
    .status_next (status_next)
  );

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (flush)     state_d = ST_FLUSH;
        else if (miss) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_valid && (cnt_q == CNT_W'(BLOCK_WORDS - 1))) state_d = ST_FILL;
      end
      ST_FILL: begin
        state_d = (flush_pend_q || flush) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_idx_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      blk_addr_q   <= '0;
      idx_q        <= '0;
      tag_lat_q    <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_idx_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        status_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            flush_idx_q <= '0;
          end else if (miss) begin
            blk_addr_q <= cpu_addr & BLK_MASK;
            idx_q      <= req_idx;
            tag_lat_q  <= req_tag;
            victim_q   <= plru_victim;
          end else if (hit) begin
            status_q[req_idx] <= status_next;
          end
        end
        ST_REQ: begin
          if (flush)   flush_pend_q <= 1'b1;
          if (mem_ack) cnt_q <= '0;
        end
        ST_REFILL: begin
          if (flush)     flush_pend_q <= 1'b1;
          if (mem_valid) cnt_q <= cnt_q + 1'b1;
        end
        ST_FILL: begin
          valid_q[idx_q]  <= valid_q[idx_q] | (ASSOC'(1) << victim_q);
          status_q[idx_q] <= status_next;
          flush_pend_q    <= 1'b0;
          flush_idx_q     <= '0;
        end
        ST_FLUSH: begin
          valid_q[flush_idx_q]  <= '0;
          status_q[flush_idx_q] <= '0;
          flush_idx_q           <= flush_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tags and data carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (state_q == ST_REFILL && mem_valid) buf_q[cnt_q] <= mem_data;
    if (state_q == ST_FILL) begin
      tag_arr[victim_q][idx_q] <= tag_lat_q;
      for (int wd = 0; wd < BLOCK_WORDS; wd++) data_arr[victim_q][idx_q][wd] <= buf_q[wd];
    end
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter ASSOC, default 2, number of ways per set (power of two, 1..8).
REQ-002 Parameter SETS, default 16, number of sets (power of two).
REQ-003 Parameter BLOCK_WORDS, default 4, 32-bit words per block (power of two, 1..16).
REQ-004 Parameter ADDR_BITS, default 32, byte address width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cpu_req  in  1  fetch request, held until cpu_ready.
REQ-008 cpu_addr  in  ADDR_BITS  byte address of the fetch; word-aligned.
REQ-009 cpu_ready  out  1  fetch complete this cycle; cpu_data valid.
REQ-010 cpu_data  out  32  fetched instruction word.
REQ-011 flush  in  1  one-cycle pulse: invalidate whole cache (fence.i).
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 mem_req  out  1  block refill request, held until mem_ack.
REQ-014 mem_addr  out  ADDR_BITS  block-aligned refill address, stable while mem_req.
REQ-015 mem_ack  in  1  memory accepted the request.
REQ-016 mem_valid  in  1  one refill beat on mem_data this cycle.
REQ-017 mem_data  in  32  refill word; beats arrive in order, word 0 first.

Function
REQ-018 Address split SHALL be [tag | index (log2 SETS) | word offset (log2 BLOCK_WORDS) | 2'b00].
REQ-019 Storage per way/set: valid bit, PLRU status bit, tag, BLOCK_WORDS data words, all flops.
REQ-020 Hit = cpu_req in IDLE with any valid way whose tag matches; lookup is combinational, cpu_ready and cpu_data assert in the same cycle (zero-cycle hit).
REQ-021 FSM states: IDLE, REQ, REFILL, FILL, FLUSH.
REQ-022 IDLE: hit -> stay; miss -> REQ, latching block address and victim way; flush pulse -> FLUSH (flush wins over a coincident request, which gets no cpu_ready that cycle).
REQ-023 REQ: mem_req=1; on mem_ack -> REFILL with beat counter=0.
REQ-024 REFILL: each mem_valid writes mem_data into line buffer[counter], counter+1; on beat BLOCK_WORDS-1 -> FILL; mem_valid in other states ignored.
REQ-025 FILL (one cycle): write buffer, tag, valid=1 into victim way; update PLRU; -> IDLE; the retried fetch then hits.
REQ-026 Victim: lowest-numbered invalid way; else lowest-numbered way with status 0; chosen at miss time, not recomputed.
REQ-027 PLRU update on hit or fill: accessed way status=1; if that makes all ASSOC bits 1, all other ways in the set clear to 0.
REQ-028 ASSOC=1: victim always way 0; status bit unused.
REQ-029 FLUSH: clears valid and status of one set per cycle, index counter 0..SETS-1, then -> IDLE; busy held throughout; cpu_ready=0.
REQ-030 flush pulse during REQ/REFILL/FILL SHALL be recorded and executed immediately after FILL completes; the refilled line is then invalidated.
REQ-031 cpu_req dropping or cpu_addr changing during refill SHALL NOT abort the refill.
REQ-032 cpu_ready SHALL never assert outside IDLE; cpu_data is 0 when cpu_ready=0.

Reset
REQ-033 rst low: state IDLE, all valid/status bits 0, counters 0, pending flush cleared, cpu_ready=0, cpu_data=0, mem_req=0, mem_addr=0, busy=0, immediately (asynchronous).
REQ-034 Reset mid-refill SHALL drop mem_req at once; subsequent beats are ignored; tags/data need not be cleared.

Structure
REQ-035 Shared package/header: parameter defaults, derived widths (index, offset, tag), FSM state encodings.
REQ-036 One sub-module natural: icache_plru (victim select and status-update logic for one set, parametrised by ASSOC).

Verification
REQ-037 After reset, fetch 0x100 with ASSOC=2, BLOCK_WORDS=4: mem_req with mem_addr=0x100; ack, beats 0xA0..0xA3 -> FILL -> cpu_ready with cpu_data=0xA0; fetch 0x10C hits same cycle with 0xA3.
REQ-038 Three blocks mapping to set 0 (0x000, 0x400, 0x800) plus re-hit of 0x000 before 0x800: 0x400 is evicted, 0x000 still hits, 0x400 misses.
REQ-039 flush pulse in IDLE: busy high exactly SETS=16 cycles; previously hitting 0x100 then misses.
REQ-040 flush during beat 2 of refill: refill completes, FLUSH follows, fetch of same address misses again.
REQ-041 rst low after beat 1 of refill: mem_req=0 same cycle; further mem_valid ignored; fetch 0x100 after release misses and refills cleanly.
REQ-042 cpu_req withdrawn in REQ state: refill completes, block installed, later fetch hits without mem_req.
